// File: rtl/uart_tx_if.sv
// Byte-source side of the UART transmitter: baud tick, start request/data,
// ready/done status and the serial line itself.
interface uart_tx_if #(
  parameter int DBIT = 8
);
  logic            tick;
  logic            tx_start;
  logic [DBIT-1:0] din;
  logic            tx_ready;
  logic            tx_done_tick;
  logic            tx;

  modport master (
    output tick, tx_start, din,
    input  tx_ready, tx_done_tick, tx
  );

  modport slave (
    input  tick, tx_start, din,
    output tx_ready, tx_done_tick, tx
  );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DBIT data bits LSB-first, then SB_TICK ticks of stop,
// all paced by an oversampled baud tick. tx and tx_done_tick are registered.
module uart_tx #(
  parameter int DBIT       = 8,
  parameter int OVERSAMPLE = 16,
  parameter int SB_TICK    = 16
) (
  input logic      clk,
  input logic      rst_n,
  uart_tx_if.slave bus
);
  localparam int SMAX = (OVERSAMPLE > SB_TICK) ? OVERSAMPLE : SB_TICK;
  localparam int SW   = (SMAX > 1) ? $clog2(SMAX) : 1;
  localparam int NW   = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [SW-1:0] S_BIT_LAST  = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_STOP_LAST = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST      = NW'(DBIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_reg, state_next;
  logic [SW-1:0]   s_reg, s_next;
  logic [NW-1:0]   n_reg, n_next;
  logic [DBIT-1:0] b_reg, b_next;
  logic            tx_reg, tx_next;
  logic            done_reg, done_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      s_reg     <= '0;
      n_reg     <= '0;
      b_reg     <= '0;
      tx_reg    <= 1'b1;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      s_reg     <= s_next;
      n_reg     <= n_next;
      b_reg     <= b_next;
      tx_reg    <= tx_next;
      done_reg  <= done_next;
    end
  end

  // The line level for the next bit is computed here so tx stays a flop.
  always_comb begin
    state_next = state_reg;
    s_next     = s_reg;
    n_next     = n_reg;
    b_next     = b_reg;
    tx_next    = tx_reg;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        tx_next = 1'b1;
        if (bus.tx_start) begin
          b_next     = bus.din;
          s_next     = '0;
          state_next = START;
          tx_next    = 1'b0;
        end
      end
      START: begin
        if (bus.tick) begin
          if (s_reg == S_BIT_LAST) begin
            s_next     = '0;
            n_next     = '0;
            state_next = DATA;
            tx_next    = b_reg[0];
          end else begin
            s_next = s_reg + SW'(1);
          end
        end
      end
      DATA: begin
        if (bus.tick) begin
          if (s_reg == S_BIT_LAST) begin
            s_next = '0;
            b_next = b_reg >> 1;
            if (n_reg == N_LAST) begin
              state_next = STOP;
              tx_next    = 1'b1;
            end else begin
              n_next  = n_reg + NW'(1);
              tx_next = b_reg[1];
            end
          end else begin
            s_next = s_reg + SW'(1);
          end
        end
      end
      STOP: begin
        tx_next = 1'b1;
        if (bus.tick) begin
          if (s_reg == S_STOP_LAST) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            s_next = s_reg + SW'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.tx           = tx_reg;
  assign bus.tx_done_tick = done_reg;
  assign bus.tx_ready     = (state_reg == IDLE);
endmodule

// File: tb/tb_uart_tx.sv
// Randomised scoreboard bench for uart_tx: a default 8N1 instance and a
// 7-bit / 2-stop-bit instance, each decoded from the serial line.
module tb_uart_tx;
  localparam int OS = 16;

  typedef struct packed {
    logic [8:0]  d;
    logic        b2b;
    logic [15:0] clk_exp;
  } exp_t;

  function automatic int unsigned dbits(input int i);
    return (i == 0) ? 8 : 7;
  endfunction

  function automatic int unsigned frame_len(input int i);
    return (i == 0) ? (1 + 8) * OS + 16 : (1 + 7) * OS + 32;
  endfunction

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic st [2];
  logic [8:0] dn [2];
  logic tk [2] = '{1'b0, 1'b0};
  int unsigned tmode [2];
  int unsigned tper [2];
  int unsigned tcnt [2] = '{0, 0};
  logic txw [2], rdy [2], dne [2];

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned tmo_events = 0;
  bit fin_req = 1'b0;
  bit fin_ack = 1'b0;

  always #5 clk = ~clk;

  uart_tx_if #(.DBIT(8)) bus0 ();
  uart_tx_if #(.DBIT(7)) bus1 ();

  uart_tx #(.DBIT(8), .OVERSAMPLE(OS), .SB_TICK(16)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0)
  );
  uart_tx #(.DBIT(7), .OVERSAMPLE(OS), .SB_TICK(32)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );

  assign bus0.tick = tk[0];
  assign bus0.tx_start = st[0];
  assign bus0.din = dn[0][7:0];
  assign bus1.tick = tk[1];
  assign bus1.tx_start = st[1];
  assign bus1.din = dn[1][6:0];
  assign txw[0] = bus0.tx;
  assign rdy[0] = bus0.tx_ready;
  assign dne[0] = bus0.tx_done_tick;
  assign txw[1] = bus1.tx;
  assign rdy[1] = bus1.tx_ready;
  assign dne[1] = bus1.tx_done_tick;

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 2; i++) begin
      case (tmode[i])
        1: tk[i] = 1'b1;
        2: begin
          tk[i] = (tcnt[i] == 0);
          tcnt[i] = (tcnt[i] + 1 >= tper[i]) ? 0 : tcnt[i] + 1;
        end
        3: tk[i] = ($urandom_range(0, 2) == 0);
        default: tk[i] = 1'b0;
      endcase
    end
  end

  // Reference model + monitor, both in one negedge process.
  exp_t sb [2][$];
  logic smp [2][$];
  int unsigned rem [2] = '{0, 0};
  bit jd [2] = '{1'b0, 1'b0};
  bit busy [2] = '{1'b0, 1'b0};
  bit dprev [2] = '{1'b0, 1'b0};
  int unsigned start_cyc [2] = '{0, 0};
  int unsigned last_done [2] = '{0, 0};
  int unsigned cyc = 0;
  logic p_rst = 1'b0;
  logic p_st [2] = '{1'b0, 1'b0};
  logic p_tk [2] = '{1'b0, 1'b0};
  logic [8:0] p_dn [2] = '{9'd0, 9'd0};
  int unsigned p_mode [2] = '{0, 0};

  task automatic chk(input int i, input bit ok, input string name,
                     input int unsigned act, input int unsigned req);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL cfg%0d %s: got 0x%0h, want 0x%0h (t=%0t)", i, name, act, req, $time);
    end
  endtask

  task automatic check_frame(input int i, input exp_t e);
    int unsigned nb = dbits(i);
    int unsigned fl = frame_len(i);
    int unsigned bad = 0;
    int unsigned act = 0;
    logic want;
    chk(i, smp[i].size() == fl, "frame_ticks", smp[i].size(), fl);
    for (int j = 0; j < smp[i].size(); j++) begin
      int unsigned k = j / OS;
      if (k == 0) want = 1'b0;
      else if (k <= nb) want = e.d[k-1];
      else want = 1'b1;
      if (smp[i][j] !== want) bad++;
    end
    chk(i, bad == 0, "frame_wave_bad_ticks", bad, 0);
    for (int k = 0; k < nb; k++) begin
      int unsigned idx = (k + 1) * OS + OS / 2;
      if (idx < smp[i].size() && smp[i][idx] === 1'b1) act |= (1 << k);
    end
    chk(i, act == 32'(e.d), "data", act, 32'(e.d));
    if (e.clk_exp != 0)
      chk(i, cyc - start_cyc[i] == 32'(e.clk_exp), "done_latency_clk",
          cyc - start_cyc[i], 32'(e.clk_exp));
  endtask

  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      // Model step for the edge just past, using inputs latched last negedge.
      if (!p_rst) begin
        if (rem[i] != 0 && sb[i].size() != 0) sb[i].delete(sb[i].size() - 1);
        rem[i] = 0;
        jd[i] = 1'b0;
      end else if (rem[i] != 0) begin
        if (p_tk[i]) rem[i]--;
        jd[i] = (rem[i] == 0);
      end else begin
        if (p_st[i]) begin
          exp_t e;
          e.d = p_dn[i] & 9'((1 << dbits(i)) - 1);
          e.b2b = jd[i];
          e.clk_exp = (p_mode[i] == 1) ? 16'(frame_len(i)) : 16'd0;
          sb[i].push_back(e);
          rem[i] = frame_len(i);
        end
        jd[i] = 1'b0;
      end

      if (!p_rst) begin
        chk(i, txw[i] === 1'b1 && rdy[i] === 1'b1 && dne[i] === 1'b0, "reset_outputs",
            {29'd0, txw[i], rdy[i], dne[i]}, 32'h6);
        busy[i] = 1'b0;
        dprev[i] = 1'b0;
      end else begin
        chk(i, rdy[i] === (rem[i] == 0), "tx_ready", 32'(rdy[i]), 32'(rem[i] == 0));
        if (dne[i] === 1'b1) begin
          chk(i, !dprev[i], "done_width", 32'(dprev[i]) + 1, 1);
          chk(i, busy[i] && sb[i].size() != 0, "done_expected", 32'(busy[i]), 1);
          if (busy[i] && sb[i].size() != 0) check_frame(i, sb[i].pop_front());
          busy[i] = 1'b0;
          last_done[i] = cyc;
        end else begin
          if (!busy[i] && txw[i] === 1'b0) begin
            chk(i, sb[i].size() != 0, "start_expected", 0, 1);
            if (sb[i].size() != 0 && sb[i][0].b2b)
              chk(i, cyc == last_done[i] + 1, "b2b_gap_clk", cyc - last_done[i], 1);
            busy[i] = 1'b1;
            smp[i].delete();
            start_cyc[i] = cyc;
          end
          if (busy[i] && tk[i] === 1'b1) smp[i].push_back(txw[i]);
        end
        dprev[i] = (dne[i] === 1'b1);
      end
      p_st[i] = st[i];
      p_dn[i] = dn[i];
      p_tk[i] = tk[i];
      p_mode[i] = tmode[i];
    end
    p_rst = rst_n;
    if (fin_req && !fin_ack) begin
      chk(0, sb[0].size() == 0, "frames_outstanding", sb[0].size(), 0);
      chk(1, sb[1].size() == 0, "frames_outstanding", sb[1].size(), 0);
      chk(0, tmo_events == 0, "wait_timeouts", tmo_events, 0);
      fin_ack = 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int i);
    int unsigned k = 0;
    while (rdy[i] !== 1'b1 && k < 3000) begin step(); k++; end
    if (rdy[i] !== 1'b1) tmo_events++;
  endtask

  task automatic wait_done(input int i);
    int unsigned k = 0;
    while (dne[i] !== 1'b1 && k < 3000) begin step(); k++; end
    if (dne[i] !== 1'b1) tmo_events++;
  endtask

  task automatic send(input int i, input logic [8:0] d);
    st[i] = 1'b1;
    dn[i] = d;
    step();
    st[i] = 1'b0;
    dn[i] = 9'($urandom);
  endtask

  initial begin
    st = '{1'b0, 1'b0};
    dn = '{9'd0, 9'd0};
    tmode = '{3, 3};
    tper = '{3, 3};
    // Reset with random inputs.
    repeat (3) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        st[i] = 1'($urandom_range(0, 1));
        dn[i] = 9'($urandom);
      end
    end
    step();
    rst_n = 1'b1;
    st = '{1'b0, 1'b0};
    tmode = '{1, 2};
    step();

    // 0x55 with tick every clk.
    wait_ready(0);
    send(0, 9'h055);
    wait_done(0);
    step();

    // Back-to-back frames started in the done cycle.
    send(0, 9'h000);
    begin
      logic [8:0] seq [3];
      seq = '{9'h0FF, 9'h0A5, 9'h03C};
      for (int k = 0; k < 3; k++) begin
        wait_done(0);
        send(0, seq[k]);
      end
    end
    wait_done(0);
    step();

    // Start request mid-frame is dropped.
    send(0, 9'h081);
    repeat (38) step();
    send(0, 9'h07E);
    wait_done(0);
    repeat (250) step();

    // Reset during data bit 3.
    send(0, 9'h0C3);
    repeat (70) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (300) step();

    // 7-bit instance, 2 stop bits, tick every 3rd clk.
    tper[1] = 3;
    wait_ready(1);
    send(1, 9'h05A);
    wait_done(1);
    step();

    // Random segments: random tick modes, start pulses and rare resets.
    for (int seg = 0; seg < 4; seg++) begin
      wait_ready(0);
      wait_ready(1);
      for (int i = 0; i < 2; i++) begin
        tmode[i] = $urandom_range(1, 3);
        tper[i] = $urandom_range(2, 4);
      end
      repeat (1200) begin
        for (int i = 0; i < 2; i++) begin
          st[i] = ($urandom_range(0, 59) == 0);
          dn[i] = 9'($urandom);
        end
        rst_n = ($urandom_range(0, 1999) != 0);
        step();
      end
      st = '{1'b0, 1'b0};
      rst_n = 1'b1;
      step();
    end

    wait_ready(0);
    wait_ready(1);
    repeat (5) step();
    fin_req = 1'b1;
    for (int k = 0; k < 10 && !fin_ack; k++) step();
    if (!fin_ack) begin
      $display("FAIL final_check: monitor did not respond");
      $fatal(1, "final check not reached");
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
